// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Data-memory port of the memory/writeback stage.
//   memReq   : request is active (stage -> memory)
//   memWe    : request is a write (stage -> memory)
//   memAddr  : 16-bit word address (stage -> memory)
//   memWdata : 24-bit store data (stage -> memory)
//   memRdata : 24-bit load data, valid with memAck (memory -> stage)
//   memAck   : memory completes the request this cycle (memory -> stage)
// master = the pipeline stage, slave = the memory.
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
  logic        memReq;
  logic        memWe;
  logic [15:0] memAddr;
  logic [23:0] memWdata;
  logic [23:0] memRdata;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memRdata, memAck
  );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory/writeback stage. Takes the execute-stage bundle, performs loads and
// stores over a handshaked memory port, and registers the writeback bundle
// that goes back to the register file write port. While an access is in
// flight, upstream is stalled; an access that receives no ack within TIMEOUT
// cycles is aborted and flagged in the sticky memErr.
//
// Parameters
//   TIMEOUT     : max ACCESS cycles without memAck before abort (>= 1)
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   i_validE    : execute bundle valid
//   i_regWriteE : instruction writes the register file
//   i_memToRegE : load
//   i_memWriteE : store (takes precedence over memToRegE)
//   i_WA3E      : destination register
//   i_aluResE   : ALU result, [15:0] is the memory address
//   i_dataE     : store data
//   o_stall     : upstream must hold the E inputs
//   mem         : memory port (master side)
//   o_regWriteW : writeback enable, one-cycle pulse
//   o_WA3W      : writeback register
//   o_result    : writeback data
//   o_memErr    : sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_validE,
  input  logic                 i_regWriteE,
  input  logic                 i_memToRegE,
  input  logic                 i_memWriteE,
  input  logic [3:0]           i_WA3E,
  input  logic [23:0]          i_aluResE,
  input  logic [23:0]          i_dataE,
  output logic                 o_stall,
  mem_wb_stage_if.master       mem,
  output logic                 o_regWriteW,
  output logic [3:0]           o_WA3W,
  output logic [23:0]          o_result,
  output logic                 o_memErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [CW-1:0] r_count;
  logic        r_memWe;
  logic [15:0] r_memAddr;
  logic [23:0] r_memWdata;
  logic [3:0]  r_wa3Lat;
  logic        r_regWriteLat;
  logic        w_memOp;
  logic        w_timeout;
  logic        w_memReq;
  logic        w_stall;

  assign w_memOp   = i_validE & (i_memToRegE | i_memWriteE);
  // Abort only when the budget is spent and memory did not answer; a
  // coincident ack wins.
  assign w_timeout = (r_state == ACCESS) && !mem.memAck && (r_count == LAST_COUNT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_memOp) w_nextState = ACCESS;
      ACCESS:  if (mem.memAck || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: request follows the state, stall releases in the cycle the
  // access finishes so upstream advances on that same edge.
  always_comb begin
    w_memReq = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_memOp;
      ACCESS: begin
        w_memReq = 1'b1;
        w_stall  = !(mem.memAck || w_timeout);
      end
      default: begin
        w_memReq = 1'b0;
        w_stall  = 1'b0;
      end
    endcase
  end

  assign mem.memReq   = w_memReq;
  assign mem.memWe    = r_memWe;
  assign mem.memAddr  = r_memAddr;
  assign mem.memWdata = r_memWdata;
  assign o_stall      = w_stall;

  // Access cycle counter; saturates at the last budgeted count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_state == IDLE) begin
      r_count <= '0;
    end else if (r_count != LAST_COUNT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Memory request fields and latched writeback info, captured only in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memWe       <= 1'b0;
      r_memAddr     <= '0;
      r_memWdata    <= '0;
      r_wa3Lat      <= '0;
      r_regWriteLat <= 1'b0;
    end else if (r_state == IDLE && w_memOp) begin
      r_memWe       <= i_memWriteE;
      r_memAddr     <= i_aluResE[15:0];
      r_memWdata    <= i_dataE;
      r_wa3Lat      <= i_WA3E;
      // A store never writes back, even with memToRegE set.
      r_regWriteLat <= i_regWriteE & ~i_memWriteE;
    end
  end

  // Writeback bundle and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_regWriteW <= 1'b0;
      o_WA3W      <= '0;
      o_result    <= '0;
      o_memErr    <= 1'b0;
    end else begin
      o_regWriteW <= 1'b0;
      if (r_state == IDLE) begin
        if (i_validE && !w_memOp) begin
          o_result    <= i_aluResE;
          o_WA3W      <= i_WA3E;
          o_regWriteW <= i_regWriteE;
        end
      end else begin
        if (mem.memAck) begin
          if (!r_memWe) begin
            o_result    <= mem.memRdata;
            o_WA3W      <= r_wa3Lat;
            o_regWriteW <= r_regWriteLat;
          end
        end else if (w_timeout) begin
          o_memErr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed bench for mem_wb_stage with TIMEOUT=4. Each task drives one
// scenario and compares the DUT against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        validE;
  logic        regWriteE;
  logic        memToRegE;
  logic        memWriteE;
  logic [3:0]  WA3E;
  logic [23:0] aluResE;
  logic [23:0] dataE;
  logic        stall;
  logic        regWriteW;
  logic [3:0]  WA3W;
  logic [23:0] result;
  logic        memErr;

  int checks = 0;
  int errors = 0;

  mem_wb_stage_if memIf ();

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_validE    (validE),
    .i_regWriteE (regWriteE),
    .i_memToRegE (memToRegE),
    .i_memWriteE (memWriteE),
    .i_WA3E      (WA3E),
    .i_aluResE   (aluResE),
    .i_dataE     (dataE),
    .o_stall     (stall),
    .mem         (memIf.master),
    .o_regWriteW (regWriteW),
    .o_WA3W      (WA3W),
    .o_result    (result),
    .o_memErr    (memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the execute bundle in one go.
  task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                               input logic mw, input logic [3:0] wa,
                               input logic [23:0] alu, input logic [23:0] d);
    validE    = v;
    regWriteE = rw;
    memToRegE = m2r;
    memWriteE = mw;
    WA3E      = wa;
    aluResE   = alu;
    dataE     = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    memIf.memAck   = 1'b0;
    memIf.memRdata = 24'd0;
    #2;
    checks++; if (memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_memReq got=%0h exp=0", memIf.memReq); end
    checks++; if (regWriteW !== 1'b0) begin errors++; $display("[TB] FAIL reset_regWriteW got=%0h exp=0", regWriteW); end
    checks++; if (memErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_memErr got=%0h exp=0", memErr); end
    checks++; if (result !== 24'd0 || WA3W !== 4'd0) begin errors++; $display("[TB] FAIL reset_wb got=%0h/%0h exp=0/0", result, WA3W); end
    checks++; if (memIf.memAddr !== 16'd0 || memIf.memWdata !== 24'd0 || memIf.memWe !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_memPort got=%0h/%0h/%0h exp=0/0/0", memIf.memAddr, memIf.memWdata, memIf.memWe);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_alu();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 24'h00ABCD, 24'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall got=%0h exp=0", stall); end
    tick();
    checks++; if (regWriteW !== 1'b1) begin errors++; $display("[TB] FAIL alu_regWriteW got=%0h exp=1", regWriteW); end
    checks++; if (WA3W !== 4'd5) begin errors++; $display("[TB] FAIL alu_WA3W got=%0h exp=5", WA3W); end
    checks++; if (result !== 24'h00ABCD) begin errors++; $display("[TB] FAIL alu_result got=%0h exp=00abcd", result); end
    // Idle with a stray ack: nothing retires, nothing is requested, result holds.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 24'h111111, 24'd0);
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'h999999;
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b0) begin errors++; $display("[TB] FAIL idle_regWriteW got=%0h exp=0", regWriteW); end
    checks++; if (memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL idle_memReq got=%0h exp=0", memIf.memReq); end
    checks++; if (result !== 24'h00ABCD || WA3W !== 4'd5) begin errors++; $display("[TB] FAIL idle_hold got=%0h/%0h exp=00abcd/5", result, WA3W); end
  endtask

  task automatic test_load_latency();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 24'h001234, 24'd0);
    #1;
    checks++; if (stall !== 1'b1 || memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL ld_N got=stall %0h req %0h exp=1 0", stall, memIf.memReq); end
    tick();
    // E inputs change during ACCESS and must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 24'h00FFFF, 24'h123456);
    #1;
    checks++; if (memIf.memReq !== 1'b1 || memIf.memAddr !== 16'h1234 || memIf.memWe !== 1'b0) begin
      errors++; $display("[TB] FAIL ld_N1 got=req %0h addr %0h we %0h exp=1 1234 0", memIf.memReq, memIf.memAddr, memIf.memWe);
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL ld_N1_stall got=%0h exp=1", stall); end
    tick();
    checks++; if (memIf.memReq !== 1'b1 || stall !== 1'b1 || memIf.memAddr !== 16'h1234 || regWriteW !== 1'b0) begin
      errors++; $display("[TB] FAIL ld_N2 got=req %0h stall %0h addr %0h rw %0h exp=1 1 1234 0", memIf.memReq, stall, memIf.memAddr, regWriteW);
    end
    tick();
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'hC0FFEE;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ld_N3_stall got=%0h exp=0", stall); end
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd7 || result !== 24'hC0FFEE) begin
      errors++; $display("[TB] FAIL ld_wb got=%0h/%0h/%0h exp=1/7/c0ffee", regWriteW, WA3W, result);
    end
    checks++; if (memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL ld_N4_memReq got=%0h exp=0", memIf.memReq); end
    tick();
    checks++; if (regWriteW !== 1'b0) begin errors++; $display("[TB] FAIL ld_pulse got=%0h exp=0", regWriteW); end
  endtask

  task automatic test_store();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 24'h000010, 24'h5A5A5A);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL st_stall got=%0h exp=1", stall); end
    tick();
    checks++; if (memIf.memReq !== 1'b1 || memIf.memWe !== 1'b1 || memIf.memWdata !== 24'h5A5A5A || memIf.memAddr !== 16'h0010) begin
      errors++; $display("[TB] FAIL st_port got=req %0h we %0h wd %0h addr %0h exp=1 1 5a5a5a 0010", memIf.memReq, memIf.memWe, memIf.memWdata, memIf.memAddr);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'h777777;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL st_ack_stall got=%0h exp=0", stall); end
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b0 || memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL st_wb got=rw %0h req %0h exp=0 0", regWriteW, memIf.memReq); end
    checks++; if (result !== 24'hC0FFEE || WA3W !== 4'd7) begin errors++; $display("[TB] FAIL st_hold got=%0h/%0h exp=c0ffee/7", result, WA3W); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 24'h000020, 24'd0);
    tick();
    // Zero-wait ack; upstream advances and presents the next load.
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'h111111;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 24'h000030, 24'd0);
    #1;
    checks++; if (memIf.memReq !== 1'b1 || memIf.memAddr !== 16'h0020 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_a got=req %0h addr %0h stall %0h exp=1 0020 0", memIf.memReq, memIf.memAddr, stall);
    end
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd2 || result !== 24'h111111) begin
      errors++; $display("[TB] FAIL b2b_wbA got=%0h/%0h/%0h exp=1/2/111111", regWriteW, WA3W, result);
    end
    checks++; if (memIf.memReq !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap got=req %0h stall %0h exp=0 1", memIf.memReq, stall); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'h222222;
    #1;
    checks++; if (memIf.memReq !== 1'b1 || memIf.memAddr !== 16'h0030 || regWriteW !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_b got=req %0h addr %0h rw %0h exp=1 0030 0", memIf.memReq, memIf.memAddr, regWriteW);
    end
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd4 || result !== 24'h222222) begin
      errors++; $display("[TB] FAIL b2b_wbB got=%0h/%0h/%0h exp=1/4/222222", regWriteW, WA3W, result);
    end
  endtask

  task automatic test_ack_at_timeout();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd10, 24'h000050, 24'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    tick();
    tick();
    tick();
    // Fourth ACCESS cycle: ack coincides with the budget running out.
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'hABC123;
    #1;
    checks++; if (memIf.memReq !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL ackto_c4 got=req %0h stall %0h exp=1 0", memIf.memReq, stall); end
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd10 || result !== 24'hABC123) begin
      errors++; $display("[TB] FAIL ackto_wb got=%0h/%0h/%0h exp=1/a/abc123", regWriteW, WA3W, result);
    end
    checks++; if (memErr !== 1'b0) begin errors++; $display("[TB] FAIL ackto_memErr got=%0h exp=0", memErr); end
  endtask

  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 24'h000040, 24'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    for (int i = 0; i < 8; i++) begin
      if (memIf.memReq === 1'b1) begin
        reqCycles++;
        #1;
        checks++; if (stall !== (reqCycles < 4)) begin errors++; $display("[TB] FAIL to_stall c%0d got=%0h exp=%0h", reqCycles, stall, (reqCycles < 4)); end
        @(posedge clk);
        #1;
      end
    end
    checks++; if (reqCycles !== 4) begin errors++; $display("[TB] FAIL to_reqCycles got=%0d exp=4", reqCycles); end
    checks++; if (memErr !== 1'b1 || regWriteW !== 1'b0) begin errors++; $display("[TB] FAIL to_err got=err %0h rw %0h exp=1 0", memErr, regWriteW); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 24'h000777, 24'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd6 || result !== 24'h000777) begin
      errors++; $display("[TB] FAIL to_alu got=%0h/%0h/%0h exp=1/6/777", regWriteW, WA3W, result);
    end
    checks++; if (memErr !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky got=%0h exp=1", memErr); end
  endtask

  task automatic test_reset_mid_access();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 24'h00BEEF, 24'h0000AA);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    checks++; if (memIf.memReq !== 1'b1) begin errors++; $display("[TB] FAIL rstm_pre got=%0h exp=1", memIf.memReq); end
    rst = 1'b1;
    #1;
    checks++; if (memIf.memReq !== 1'b0 || regWriteW !== 1'b0 || memErr !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL rstm_ctrl got=req %0h rw %0h err %0h stall %0h exp=0 0 0 0", memIf.memReq, regWriteW, memErr, stall);
    end
    checks++; if (memIf.memAddr !== 16'd0 || result !== 24'd0 || WA3W !== 4'd0 || memIf.memWe !== 1'b0) begin
      errors++; $display("[TB] FAIL rstm_data got=addr %0h res %0h wa %0h we %0h exp=0 0 0 0", memIf.memAddr, result, WA3W, memIf.memWe);
    end
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd11, 24'h000060, 24'd0);
    #1;
    checks++; if (stall !== 1'b1 || memIf.memReq !== 1'b0) begin errors++; $display("[TB] FAIL rstm_idle got=stall %0h req %0h exp=1 0", stall, memIf.memReq); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0);
    memIf.memAck   = 1'b1;
    memIf.memRdata = 24'h0F0F0F;
    tick();
    memIf.memAck = 1'b0;
    checks++; if (regWriteW !== 1'b1 || WA3W !== 4'd11 || result !== 24'h0F0F0F || memErr !== 1'b0) begin
      errors++; $display("[TB] FAIL rstm_after got=%0h/%0h/%0h/%0h exp=1/b/0f0f0f/0", regWriteW, WA3W, result, memErr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_latency();
    test_store();
    test_back_to_back();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
